rv_iopmp_entry_bram_arbiter: RTL and testbench
==============================================

Name: rv_iopmp_entry_bram_arbiter

Overview:
Shares the single-port IOPMP entry BRAM between two kinds of requester. The config side comes from the regmap width converter and does 128-bit reads and writes with byte enables. NUMBER_REQ lookup walkers in the IOPMP checkers do 128-bit reads only. It arbitrates each cycle, drives the BRAM, and routes 1-cycle-latency read data back to the granted requester. It sits between the regmap wrapper's BRAM port and the physical entry BRAM.

Parameters:
NUMBER_ENTRIES, 8, BRAM depth; AW = max(1, $clog2(NUMBER_ENTRIES))
NUMBER_REQ, 2, number of lookup requesters (>=1)
BRAM_DWIDTH, 128, BRAM word width; BE width = BRAM_DWIDTH/8
CFG_BURST_MAX, 4, max consecutive config grants while any lookup is pending (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cfg_req_i  in  1  config access request
cfg_we_i  in  1  1=write, 0=read
cfg_addr_i  in  AW  config entry index
cfg_din_i  in  BRAM_DWIDTH  write data
cfg_be_i  in  BRAM_DWIDTH/8  write byte enables
cfg_gnt_o  out  1  config request accepted this cycle
cfg_rvalid_o  out  1  config read data valid
cfg_rdata_o  out  BRAM_DWIDTH  config read data
lk_req_i  in  NUMBER_REQ  lookup read requests
lk_addr_i  in  NUMBER_REQ*AW  packed lookup indices; requester i at [i*AW +: AW]
lk_gnt_o  out  NUMBER_REQ  one-hot lookup grant
lk_rvalid_o  out  NUMBER_REQ  one-hot lookup read-data valid
lk_rdata_o  out  BRAM_DWIDTH  lookup read data, shared by all lookup requesters
bram_en_o  out  1  BRAM enable
bram_we_o  out  1  BRAM write enable
bram_addr_o  out  AW  BRAM address
bram_din_o  out  BRAM_DWIDTH  BRAM write data
bram_be_o  out  BRAM_DWIDTH/8  BRAM byte enables
bram_dout_i  in  BRAM_DWIDTH  BRAM read data, valid 1 cycle after en

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; streak=0; pending-read register empty.
- Grants are combinational from requests and state. At most one grant per cycle in total. Requester holds req, addr, data and be stable until it sees its gnt.
- Priority:
  - Config wins over lookups unless streak==CFG_BURST_MAX and some lk_req_i is set. In that case lookups win that cycle.
  - Lookups are granted round-robin starting at rr_ptr. After granting lookup k, rr_ptr <= (k+1) mod NUMBER_REQ.
- Streak counter:
  - +1 per config grant while any lk_req_i is high, saturating at CFG_BURST_MAX.
  - Cleared on any lookup grant, or in any cycle with no lk_req_i.
- BRAM drive in the grant cycle: bram_en_o=1 and bram_addr_o=granted address.
  - Config write: bram_we_o=1, din=cfg_din_i, be=cfg_be_i.
  - Reads: we=0, be=0, din=0.
  - No grant: en=0, we=0, address/data/be=0.
- Out-of-range address (addr >= NUMBER_ENTRIES, non-power-of-2 depth):
  - The request is still granted, but bram_en_o=0.
  - A read returns rvalid 1 cycle later with rdata=0.
  - A write is dropped silently.
- Read latency: exactly 1 cycle from gnt to rvalid.
  - In the cycle after a read grant, only the owner's rvalid is high, for 1 cycle. Its rdata = bram_dout_i, or 0 if out of range.
  - cfg_rdata_o and lk_rdata_o are 0 when their rvalid is low.
  - Writes produce no rvalid.
- Back-to-back grants are allowed every cycle. A pending read and a new grant coexist; the pending register holds only the owner id plus an OOR flag.
- Write-then-read to the same address in consecutive cycles: the read returns the new data, because BRAM write completes at the edge. No forwarding logic is needed.
- Reset asserted mid-operation: pending rvalid is discarded and state returns to reset values asynchronously.
- A requester dropping req without gnt is legal. Nothing is issued for it.

Test Plan:
- cfg read addr 3 alone, BRAM word 3 = 0xA5..A5 -> cfg_gnt_o at t, bram_en_o=1/addr=3 at t, cfg_rvalid_o with 0xA5..A5 at t+1, lk_* stay 0.
- cfg write addr 2 data 0x1234 be=0x000F at t, lk0 read addr 2 at t+1 -> BRAM write at t (be 0x000F), lk_gnt_o=01 at t+1, lk_rvalid_o=01 with data low bytes 0x1234 at t+2.
- lk_req_i=11 held for 6 cycles, no cfg -> grants alternate 01,10,01,10,01,10; each rvalid follows its grant by 1 cycle.
- cfg_req_i and lk_req_i=01 held high 12 cycles, CFG_BURST_MAX=4 -> cfg granted 4 cycles, lk0 1 cycle, repeating (pattern 4:1), streak never exceeds 4.
- NUMBER_ENTRIES=6, cfg read addr 7 then write addr 6 -> both granted, bram_en_o=0 both cycles, read returns cfg_rvalid_o=1 rdata=0, BRAM contents unchanged.
- lk1 read granted at t, rst_ni low at t+1 for 1 cycle -> lk_rvalid_o=0 throughout, all outputs 0, after release rr_ptr=0 so lk_req_i=11 grants lk0 first.

Source files
------------

// File: rtl/rv_iopmp_entry_bram_arbiter.sv
// Arbitrates the single-port IOPMP entry BRAM between the config port and the lookup walkers,
// and steers the one-cycle-latency read data back to whichever requester owned the read.
module rv_iopmp_entry_bram_arbiter #(
    parameter int NUMBER_ENTRIES = 8,
    parameter int NUMBER_REQ     = 2,
    parameter int BRAM_DWIDTH    = 128,
    parameter int CFG_BURST_MAX  = 4,
    localparam int AW = (NUMBER_ENTRIES > 1) ? $clog2(NUMBER_ENTRIES) : 1,
    localparam int BW = BRAM_DWIDTH / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cfg_req_i,
    input  logic                     cfg_we_i,
    input  logic [AW-1:0]            cfg_addr_i,
    input  logic [BRAM_DWIDTH-1:0]   cfg_din_i,
    input  logic [BW-1:0]            cfg_be_i,
    output logic                     cfg_gnt_o,
    output logic                     cfg_rvalid_o,
    output logic [BRAM_DWIDTH-1:0]   cfg_rdata_o,
    input  logic [NUMBER_REQ-1:0]    lk_req_i,
    input  logic [NUMBER_REQ*AW-1:0] lk_addr_i,
    output logic [NUMBER_REQ-1:0]    lk_gnt_o,
    output logic [NUMBER_REQ-1:0]    lk_rvalid_o,
    output logic [BRAM_DWIDTH-1:0]   lk_rdata_o,
    output logic                     bram_en_o,
    output logic                     bram_we_o,
    output logic [AW-1:0]            bram_addr_o,
    output logic [BRAM_DWIDTH-1:0]   bram_din_o,
    output logic [BW-1:0]            bram_be_o,
    input  logic [BRAM_DWIDTH-1:0]   bram_dout_i
);

    localparam int IW = (NUMBER_REQ > 1) ? $clog2(NUMBER_REQ) : 1;
    localparam int SW = $clog2(CFG_BURST_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(CFG_BURST_MAX);
    localparam logic [AW:0]   DEPTH      = NUMBER_ENTRIES[AW:0];

    logic [IW-1:0] rr_ptr;
    logic [SW-1:0] streak;
    logic          pend_valid;
    logic          pend_cfg;
    logic          pend_oor;
    logic [IW-1:0] pend_id;

    logic          any_lk;
    logic          cfg_win;
    logic          lk_win;
    logic          lk_found;
    logic [IW-1:0] lk_sel;
    logic [AW-1:0] gnt_addr;
    logic          any_gnt;
    logic          in_range;
    logic          wr_gnt;
    logic          rd_gnt;

    // Handshake: a requester holds req/addr/data/be stable until it sees its gnt in the
    // same cycle; gnt is the acceptance, and read data returns exactly one cycle later
    // on the owner's rvalid. Dropping req before gnt is allowed and issues nothing.
    always_comb begin
        int idx;
        idx      = 0;
        lk_found = 1'b0;
        lk_sel   = '0;
        any_lk   = |lk_req_i;
        // Config is preferred until it has taken a full burst while a lookup is waiting.
        cfg_win  = rst_ni && cfg_req_i && !((streak == STREAK_MAX) && any_lk);
        lk_win   = rst_ni && any_lk && !cfg_win;
        for (int i = 0; i < NUMBER_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUMBER_REQ) idx = idx - NUMBER_REQ;
            if (!lk_found && lk_req_i[IW'(idx)]) begin
                lk_found = 1'b1;
                lk_sel   = IW'(idx);
            end
        end
    end

    always_comb begin
        gnt_addr = cfg_win ? cfg_addr_i : lk_addr_i[lk_sel*AW +: AW];
        any_gnt  = cfg_win || lk_win;
        in_range = ({1'b0, gnt_addr} < DEPTH);
        wr_gnt   = cfg_win && cfg_we_i;
        rd_gnt   = lk_win || (cfg_win && !cfg_we_i);
    end

    always_comb begin
        cfg_gnt_o = cfg_win;
        for (int i = 0; i < NUMBER_REQ; i++) begin
            lk_gnt_o[i] = lk_win && (lk_sel == IW'(i));
        end
        bram_en_o   = any_gnt && in_range;
        bram_we_o   = wr_gnt && in_range;
        bram_addr_o = any_gnt ? gnt_addr : '0;
        bram_din_o  = (wr_gnt && in_range) ? cfg_din_i : '0;
        bram_be_o   = (wr_gnt && in_range) ? cfg_be_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr     <= '0;
            streak     <= '0;
            pend_valid <= 1'b0;
            pend_cfg   <= 1'b0;
            pend_oor   <= 1'b0;
            pend_id    <= '0;
        end else begin
            if (lk_win) begin
                rr_ptr <= (lk_sel == IW'(NUMBER_REQ - 1)) ? '0 : lk_sel + 1'b1;
            end
            if (lk_win || !any_lk) begin
                streak <= '0;
            end else if (cfg_win && (streak != STREAK_MAX)) begin
                streak <= streak + 1'b1;
            end
            // Only the owner and the out-of-range flag are kept; the data comes from the BRAM.
            pend_valid <= rd_gnt;
            pend_cfg   <= cfg_win;
            pend_oor   <= !in_range;
            pend_id    <= lk_sel;
        end
    end

    always_comb begin
        cfg_rvalid_o = pend_valid && pend_cfg;
        for (int i = 0; i < NUMBER_REQ; i++) begin
            lk_rvalid_o[i] = pend_valid && !pend_cfg && (pend_id == IW'(i));
        end
        cfg_rdata_o = (cfg_rvalid_o && !pend_oor) ? bram_dout_i : '0;
        lk_rdata_o  = ((|lk_rvalid_o) && !pend_oor) ? bram_dout_i : '0;
    end

endmodule

// File: tb/tb_rv_iopmp_entry_bram_arbiter.sv
// Bench for the entry BRAM arbiter: directed vector table, reset corner, then
// randomized traffic against a cycle-level reference model with its own copy of the memory.
module tb_rv_iopmp_entry_bram_arbiter;

  localparam int NE = 6;
  localparam int NR = 2;
  localparam int DW = 128;
  localparam int BM = 4;
  localparam int AW = 3;
  localparam int BW = DW / 8;
  localparam int PW = DW + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           cfg_req, cfg_we;
  logic [AW-1:0]  cfg_addr;
  logic [DW-1:0]  cfg_din;
  logic [BW-1:0]  cfg_be;
  logic           cfg_gnt, cfg_rvalid;
  logic [DW-1:0]  cfg_rdata;
  logic [NR-1:0]  lk_req;
  logic [NR*AW-1:0] lk_addr;
  logic [NR-1:0]  lk_gnt, lk_rvalid;
  logic [DW-1:0]  lk_rdata;
  logic           bram_en, bram_we;
  logic [AW-1:0]  bram_addr;
  logic [DW-1:0]  bram_din;
  logic [BW-1:0]  bram_be;
  logic [DW-1:0]  bram_dout;

  rv_iopmp_entry_bram_arbiter #(
    .NUMBER_ENTRIES(NE), .NUMBER_REQ(NR), .BRAM_DWIDTH(DW), .CFG_BURST_MAX(BM)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_din_i(cfg_din), .cfg_be_i(cfg_be), .cfg_gnt_o(cfg_gnt),
    .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata),
    .lk_req_i(lk_req), .lk_addr_i(lk_addr), .lk_gnt_o(lk_gnt),
    .lk_rvalid_o(lk_rvalid), .lk_rdata_o(lk_rdata),
    .bram_en_o(bram_en), .bram_we_o(bram_we), .bram_addr_o(bram_addr),
    .bram_din_o(bram_din), .bram_be_o(bram_be), .bram_dout_i(bram_dout)
  );

  // physical BRAM stand-in; output is scrambled whenever no read was issued
  logic [DW-1:0] mem [NE];
  always @(posedge clk) begin
    if (bram_en && (int'(bram_addr) < NE) && !bram_we) begin
      bram_dout <= mem[bram_addr];
    end else begin
      bram_dout <= {$urandom, $urandom, $urandom, $urandom};
      if (bram_en && (int'(bram_addr) < NE) && bram_we) begin
        for (int b = 0; b < BW; b++) begin
          if (bram_be[b]) mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
        end
      end
    end
  end

  // reference model state
  logic [DW-1:0] ref_mem [NE];
  int m_rr;
  int m_streak;
  logic [PW-1:0] exp_q[$];
  int n_pass;
  int n_total;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // driver + model: inputs are already applied; check at negedge, advance model, move past posedge
  task automatic step(output logic e_cfg, output logic [NR-1:0] e_lk, output logic e_en);
    logic [PW-1:0] e;
    logic has, any_lk, cfg_win, grant, oor, wr;
    logic [DW-1:0] e_data;
    int lk_k, k, a;
    @(negedge clk);
    has = 1'b0;
    e = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      has = 1'b1;
    end
    e_data = e[DW-1:0];
    chk("cfg_rvalid", cfg_rvalid, has && e[PW-1]);
    chk("lk_rvalid", lk_rvalid, (has && !e[PW-1]) ? (2'b01 << e[PW-2]) : 2'b00);
    chk("cfg_rdata", cfg_rdata, (has && e[PW-1]) ? e_data : '0);
    chk("lk_rdata", lk_rdata, (has && !e[PW-1]) ? e_data : '0);

    any_lk = |lk_req;
    cfg_win = cfg_req && !((m_streak == BM) && any_lk);
    lk_k = -1;
    if (!cfg_win) begin
      for (int i = 0; i < NR; i++) begin
        k = (m_rr + i) % NR;
        if (lk_k < 0 && lk_req[k]) lk_k = k;
      end
    end
    grant = cfg_win || (lk_k >= 0);
    a = cfg_win ? int'(cfg_addr) : (lk_k >= 0 ? int'(lk_addr[lk_k*AW +: AW]) : 0);
    oor = (a >= NE);
    wr = cfg_win && cfg_we;
    e_cfg = cfg_win;
    e_lk = (lk_k >= 0) ? NR'(1 << lk_k) : '0;
    e_en = grant && !oor;
    chk("cfg_gnt", cfg_gnt, e_cfg);
    chk("lk_gnt", lk_gnt, e_lk);
    chk("bram_en", bram_en, e_en);
    chk("bram_addr", bram_addr, grant ? a : 0);
    if (!grant || !oor) begin
      chk("bram_we", bram_we, wr);
      chk("bram_din", bram_din, wr ? cfg_din : '0);
      chk("bram_be", bram_be, wr ? cfg_be : '0);
    end

    if (grant && !wr) begin
      exp_q.push_back({cfg_win, (lk_k == 1), (oor ? {DW{1'b0}} : ref_mem[a])});
    end
    if (wr && !oor) begin
      for (int b = 0; b < BW; b++) if (cfg_be[b]) ref_mem[a][b*8 +: 8] = cfg_din[b*8 +: 8];
    end
    if ((lk_k >= 0) || !any_lk) m_streak = 0;
    else if (cfg_win && m_streak < BM) m_streak++;
    if (lk_k >= 0) m_rr = (lk_k + 1) % NR;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_cfg_gnt"}, cfg_gnt, 1'b0);
    chk({tag, "_lk_gnt"}, lk_gnt, '0);
    chk({tag, "_cfg_rvalid"}, cfg_rvalid, 1'b0);
    chk({tag, "_lk_rvalid"}, lk_rvalid, '0);
    chk({tag, "_rdata"}, cfg_rdata | lk_rdata, '0);
    chk({tag, "_bram"}, {bram_en, bram_we, bram_addr, bram_be}, '0);
    chk({tag, "_din"}, bram_din, '0);
  endtask

  typedef struct {
    logic           cfg_req;
    logic           cfg_we;
    logic [AW-1:0]  cfg_addr;
    logic [DW-1:0]  din;
    logic [BW-1:0]  be;
    logic [NR-1:0]  lk_req;
    logic [NR*AW-1:0] lk_addr;
    logic           x_cfg;
    logic [NR-1:0]  x_lk;
    logic           x_en;
  } vec_t;

  vec_t tbl[$];
  logic g_cfg, g_en;
  logic [NR-1:0] g_lk;
  logic hold_cfg;
  logic [NR-1:0] hold_lk;

  initial begin
    n_pass = 0;
    n_total = 0;
    m_rr = 0;
    m_streak = 0;
    cfg_req = 0; cfg_we = 0; cfg_addr = '0; cfg_din = '0; cfg_be = '0;
    lk_req = '0; lk_addr = '0;
    bram_dout = '0;
    for (int i = 0; i < NE; i++) begin
      mem[i] = {16{8'(8'h10 + i)}};
      ref_mem[i] = mem[i];
    end
    mem[3] = {16{8'hA5}};
    ref_mem[3] = {16{8'hA5}};

    // directed vectors: {cfg_req, we, addr, din, be, lk_req, lk_addr, exp cfg_gnt, exp lk_gnt, exp en}
    tbl.push_back('{1, 0, 3'd3, '0, '0, 2'b00, 6'o00, 1, 2'b00, 1});
    tbl.push_back('{1, 1, 3'd2, 128'h1234, 16'h000F, 2'b00, 6'o00, 1, 2'b00, 1});
    tbl.push_back('{0, 0, 3'd0, '0, '0, 2'b01, 6'o02, 0, 2'b01, 1});
    tbl.push_back('{0, 0, 3'd0, '0, '0, 2'b10, 6'o10, 0, 2'b10, 1});
    for (int i = 0; i < 6; i++)
      tbl.push_back('{0, 0, 3'd0, '0, '0, 2'b11, 6'o14, 0, (i % 2 == 0) ? 2'b01 : 2'b10, 1});
    for (int i = 0; i < 12; i++)
      tbl.push_back('{1, 0, 3'd0, '0, '0, 2'b01, 6'o05, (i % 5 != 4), (i % 5 == 4) ? 2'b01 : 2'b00, 1});
    tbl.push_back('{1, 0, 3'd7, '0, '0, 2'b00, 6'o00, 1, 2'b00, 0});
    tbl.push_back('{1, 1, 3'd6, {DW{1'b1}}, {BW{1'b1}}, 2'b00, 6'o00, 1, 2'b00, 0});
    tbl.push_back('{0, 0, 3'd0, '0, '0, 2'b00, 6'o00, 0, 2'b00, 0});

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      cfg_req = tbl[r].cfg_req; cfg_we = tbl[r].cfg_we; cfg_addr = tbl[r].cfg_addr;
      cfg_din = tbl[r].din; cfg_be = tbl[r].be;
      lk_req = tbl[r].lk_req; lk_addr = tbl[r].lk_addr;
      step(g_cfg, g_lk, g_en);
      chk($sformatf("tbl%0d_cfg_gnt", r), cfg_gnt === 1'bx ? 1'b0 : g_cfg, tbl[r].x_cfg);
      chk($sformatf("tbl%0d_lk_gnt", r), g_lk, tbl[r].x_lk);
      chk($sformatf("tbl%0d_en", r), g_en, tbl[r].x_en);
      if (r == 0) chk("cfg_rd3_data", {cfg_rvalid, cfg_rdata}, {1'b1, {16{8'hA5}}});
      if (r == 2) chk("wr_then_rd", {lk_rvalid, lk_rdata[15:0]}, {2'b01, 16'h1234});
      if (r == 22) chk("oor_rd_data", {cfg_rvalid, cfg_rdata}, {1'b1, {DW{1'b0}}});
    end
    for (int i = 0; i < NE; i++) chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);

    // lk1 read granted, then reset lands on the cycle its data would return
    cfg_req = 0; lk_req = 2'b10; lk_addr = 6'o50;
    step(g_cfg, g_lk, g_en);
    chk("pre_rst_lk1_gnt", lk_gnt === 2'bxx ? 2'b00 : g_lk, 2'b10);
    lk_req = 2'b11;
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst");
    exp_q.delete();
    m_rr = 0;
    m_streak = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(g_cfg, g_lk, g_en);
    chk("post_rst_first", g_lk, 2'b01);

    // randomized traffic; unserved requesters keep their request stable
    hold_cfg = 1'b0;
    hold_lk = '0;
    for (int c = 0; c < 400; c++) begin
      if (!hold_cfg) begin
        cfg_req = 1'($urandom_range(0, 1));
        cfg_we = 1'($urandom_range(0, 1));
        cfg_addr = AW'($urandom_range(0, 7));
        cfg_din = {$urandom, $urandom, $urandom, $urandom};
        cfg_be = BW'($urandom);
      end
      for (int i = 0; i < NR; i++) begin
        if (!hold_lk[i]) begin
          lk_req[i] = ($urandom_range(0, 2) != 0);
          lk_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        end
      end
      step(g_cfg, g_lk, g_en);
      hold_cfg = cfg_req && !g_cfg;
      hold_lk = lk_req & ~g_lk;
    end
    cfg_req = 0;
    lk_req = '0;
    step(g_cfg, g_lk, g_en);
    for (int i = 0; i < NE; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
